// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared encodings, control-word type and per-state output decode
package multicycle_ctrl_pkg;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
    S_MEM_WRITE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_HALT
  } state_t;
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       fetch;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] result_src;
    logic       halted;
  } ctrl_t;
  function automatic ctrl_t decode(state_t s, logic [2:0] alu_op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_req = 1'b1; c.fetch = 1'b1; c.adr_src = ADR_PC; c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_4; end
      S_DECODE:    begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      S_MEM_ADDR:  begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; end
      S_MEM_READ:  begin c.mem_req = 1'b1; c.adr_src = ADR_ALUOUT; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.result_src = RES_MEM; end
      S_MEM_WRITE: begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = ADR_ALUOUT; end
      S_EXEC_R:    begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_ctrl = alu_op; end
      S_EXEC_I:    begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_ctrl = alu_op; end
      S_ALU_WB:    begin c.reg_write = 1'b1; c.result_src = RES_ALUOUT; end
      S_BRANCH:    begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_ctrl = ALU_SUB; c.branch = 1'b1; c.result_src = RES_ALUOUT; end
      S_HALT:      c.halted = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields, memory handshake and datapath controls
interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        adr_src;
  logic        ir_write;
  logic        pc_en;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_ctrl;
  logic [1:0]  result_src;
  logic        halted;
  logic [31:0] instret;
  logic [3:0]  state_o;
  modport master (
    input  opcode, funct3, funct7_5, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_en, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, result_src, halted, instret, state_o
  );
  modport slave (
    output opcode, funct3, funct7_5, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_en, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, result_src, halted, instret, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// alu_dec: funct3/funct7_5 to ALU operation, funct7_5 honoured only for R-type
module alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       r_type,
  output logic [2:0] alu_ctrl
);
  assign alu_ctrl = funct3 == 3'b000 ? ((r_type && funct7_5) ? ALU_SUB : ALU_ADD) :
                    funct3 == 3'b010 ? ALU_SLT :
                    funct3 == 3'b110 ? ALU_OR  :
                    funct3 == 3'b111 ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer with retire counter
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);
  state_t      state, nxt;
  ctrl_t       c;
  logic [31:0] instret;
  logic [2:0]  alu_op;
  logic        retire;
  logic        load;
  alu_dec u_alu_dec (
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .r_type   (bus.opcode == OP_R),
    .alu_ctrl (alu_op)
  );
  assign load   = bus.opcode == OP_LW;
  assign retire = state inside {S_MEM_WB, S_ALU_WB, S_BRANCH} || (state == S_MEM_WRITE && bus.mem_ready);
  // next state: memory states hold until mem_ready, decode dispatches on opcode
  always_comb begin
    nxt = state;
    case (state)
      S_RESET:     nxt = S_FETCH;
      S_FETCH:     nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    nxt = (load || bus.opcode == OP_SW) ? S_MEM_ADDR :
                         bus.opcode == OP_R   ? S_EXEC_R :
                         bus.opcode == OP_I   ? S_EXEC_I :
                         bus.opcode == OP_BEQ ? S_BRANCH : S_HALT;
      S_MEM_ADDR:  nxt = load ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nxt = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: nxt = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    nxt = S_ALU_WB;
      S_EXEC_I:    nxt = S_ALU_WB;
      S_MEM_WB:    nxt = S_FETCH;
      S_ALU_WB:    nxt = S_FETCH;
      S_BRANCH:    nxt = S_FETCH;
      S_HALT:      nxt = S_HALT;
      default:     nxt = S_RESET;
    endcase
  end
  // state, control word registered from the next state, and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RESET;
      c       <= '0;
      instret <= '0;
    end else begin
      state   <= nxt;
      c       <= decode(nxt, alu_op);
      instret <= instret + 32'(retire);
    end
  end
  assign bus.mem_req    = c.mem_req;
  assign bus.mem_we     = c.mem_we;
  assign bus.adr_src    = c.adr_src;
  assign bus.ir_write   = c.fetch & bus.mem_ready;
  assign bus.pc_en      = (c.fetch & bus.mem_ready) | (c.branch & bus.zero);
  assign bus.reg_write  = c.reg_write;
  assign bus.alu_src_a  = c.alu_src_a;
  assign bus.alu_src_b  = c.alu_src_b;
  assign bus.alu_ctrl   = c.alu_ctrl;
  assign bus.result_src = c.result_src;
  assign bus.halted     = c.halted;
  assign bus.instret    = instret;
  assign bus.state_o    = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle trace model of each instruction class checked against the controller
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {
    logic [3:0] st;
    logic [5:0] f;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] rs;
    logic       h;
  } obs_t;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75;
    logic       z;
    int         kf;
    int         km;
    int         cyc;
  } vec_t;
  int n_chk = 0;
  int n_fail = 0;
  int unsigned n_ret = 0;
  obs_t exp_q[$];
  logic rdy_q[$];
  logic zq[$];
  function automatic obs_t mk(state_t s, logic [5:0] f, logic [1:0] sa, logic [1:0] sb, logic [2:0] alu, logic [1:0] rs, logic h);
    return {4'(s), f, sa, sb, alu, rs, h};
  endfunction
  function automatic obs_t sample();
    return {bus.state_o, bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_en, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.result_src, bus.halted};
  endfunction
  function automatic logic [2:0] alu_ref(logic r, logic [2:0] f3, logic f75);
    return f3 == 3'd0 ? ((r && f75) ? 3'b001 : 3'b000) : f3 == 3'd2 ? 3'b101 :
           f3 == 3'd6 ? 3'b011 : f3 == 3'd7 ? 3'b010 : 3'b000;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  task automatic push(input obs_t o, input logic r, input logic z);
    exp_q.push_back(o);
    rdy_q.push_back(r);
    zq.push_back(z);
  endtask
  // expected cycle-by-cycle trace of one instruction; kf/km are stall cycles per request
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic z, input int kf, input int km);
    exp_q.delete(); rdy_q.delete(); zq.delete();
    bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f75;
    for (int i = 0; i <= kf; i++) begin
      logic r;
      r = (i == kf);
      push(mk(S_FETCH, {3'b100, r, r, 1'b0}, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0), r, 1'($urandom));
    end
    push(mk(S_DECODE, 6'b0, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0), 1'($urandom), 1'($urandom));
    if (op == OP_LW || op == OP_SW) begin
      push(mk(S_MEM_ADDR, 6'b0, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0), 1'($urandom), 1'($urandom));
      for (int i = 0; i <= km; i++)
        push(mk(op == OP_LW ? S_MEM_READ : S_MEM_WRITE, {1'b1, op == OP_SW, 4'b1000}, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), i == km, 1'($urandom));
      if (op == OP_LW) push(mk(S_MEM_WB, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0), 1'($urandom), 1'($urandom));
    end else if (op == OP_R || op == OP_I) begin
      push(mk(op == OP_R ? S_EXEC_R : S_EXEC_I, 6'b0, 2'b10, op == OP_R ? 2'b00 : 2'b01, alu_ref(op == OP_R, f3, f75), 2'b00, 1'b0), 1'($urandom), 1'($urandom));
      push(mk(S_ALU_WB, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), 1'($urandom), 1'($urandom));
    end else if (op == OP_BEQ) begin
      push(mk(S_BRANCH, {4'b0000, z, 1'b0}, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0), 1'($urandom), z);
    end else begin
      for (int i = 0; i < 20; i++) push(mk(S_HALT, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1), 1'($urandom), 1'($urandom));
    end
  endtask
  // apply the trace (or its first lim steps); ret_at = step count at which instret moved
  task automatic run(input string nm, input int lim, input bit retires, output int ret_at);
    int n;
    n = (lim < 0) ? exp_q.size() : lim;
    ret_at = -1;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = rdy_q[i];
      bus.zero = zq[i];
      @(negedge clk);
      check($sformatf("%s step%0d", nm, i), 32'(sample()), 32'(exp_q[i]));
      @(posedge clk); #1;
      if (ret_at < 0 && bus.instret != n_ret) ret_at = i + 1;
    end
    if (retires) begin
      n_ret++;
      check({nm, " instret"}, bus.instret, n_ret);
    end
  endtask
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #2;
    check({nm, " outputs"}, 32'(sample()), 32'(mk(S_RESET, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0)));
    check({nm, " instret"}, bus.instret, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_ret = 0;
    @(negedge clk);
    check({nm, " hold"}, 32'(sample()), 32'(mk(S_RESET, 6'b0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0)));
    @(posedge clk); #1;
  endtask
  initial begin
    vec_t v[12];
    logic [6:0] ops[5];
    int r;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ};
    v[0]  = '{OP_R,   3'd0, 1'b0, 1'b0, 0, 0, 4};
    v[1]  = '{OP_SW,  3'd2, 1'b0, 1'b0, 0, 0, 4};
    v[2]  = '{OP_LW,  3'd2, 1'b0, 1'b0, 0, 2, 7};
    v[3]  = '{OP_BEQ, 3'd0, 1'b0, 1'b1, 0, 0, 3};
    v[4]  = '{OP_BEQ, 3'd0, 1'b0, 1'b0, 0, 0, 3};
    v[5]  = '{OP_R,   3'd0, 1'b1, 1'b0, 0, 0, 4};
    v[6]  = '{OP_I,   3'd0, 1'b1, 1'b0, 0, 0, 4};
    v[7]  = '{OP_R,   3'd2, 1'b0, 1'b0, 0, 0, 4};
    v[8]  = '{OP_I,   3'd6, 1'b0, 1'b0, 0, 0, 4};
    v[9]  = '{OP_R,   3'd7, 1'b1, 1'b0, 0, 0, 4};
    v[10] = '{OP_R,   3'd4, 1'b0, 1'b0, 3, 0, 7};
    v[11] = '{OP_SW,  3'd2, 1'b0, 1'b0, 1, 2, 7};
    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset("rst0");
    foreach (v[i]) begin
      build(v[i].op, v[i].f3, v[i].f75, v[i].z, v[i].kf, v[i].km);
      run($sformatf("vec%0d", i), -1, 1'b1, r);
      check($sformatf("vec%0d cycles", i), 32'(r), 32'(v[i].cyc));
    end
    for (int k = 0; k < 30; k++) begin
      build(ops[$urandom_range(4)], 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(2), $urandom_range(2));
      run($sformatf("rnd%0d", k), -1, 1'b1, r);
    end
    build(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);
    run("halt", -1, 1'b0, r);
    check("halt instret", bus.instret, n_ret);
    do_reset("rst_halt");
    build(OP_LW, 3'd2, 1'b0, 1'b0, 0, 10);
    run("lw_cut", 5, 1'b0, r);
    do_reset("rst_lw");
    build(OP_R, 3'd0, 1'b0, 1'b0, 0, 0);
    run("post_rst", -1, 1'b1, r);
    check("post_rst cycles", 32'(r), 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
